dac_sample_scheduler: RTL and testbench

Paces float32 sine samples into the float-to-offset-binary 14-bit converter at a programmable sample rate and retimes the converter result into a strobed DAC word. Buffers incoming samples in a small FIFO with a valid/ready handshake. Tracks converter latency with a tag delay line, because the converter has no valid signal. On underrun it substitutes midscale (0.0). Sits between the sine sample source and the converter/DAC interface.

---
 rtl/dac_sample_scheduler.sv | 172 +++++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// rtl/dac_sample_scheduler.sv - paces float32 samples into the DAC converter and retimes its result into a strobed DAC word

module dac_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Callers gate push with !full and pop with !empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

module dac_sample_scheduler #(
    parameter int FIFO_DEPTH   = 8,
    parameter int PRIME_LEVEL  = 4,
    parameter int DIV_WIDTH    = 16,
    parameter int CONV_LATENCY = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          rate_div,
    input  logic                          clr_stats,
    input  logic [31:0]                   s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [31:0]                   conv_float,
    input  logic [13:0]                   conv_data,
    output logic [13:0]                   dac_data,
    output logic                          dac_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_cnt,
    output logic                          busy
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  run;
    logic                  tick;
    logic                  push;
    logic                  pop;
    logic                  underrun;
    logic                  full;
    logic                  empty;
    logic                  prime_met;
    logic [31:0]           head;
    logic [DIV_WIDTH-1:0]  tick_cnt;
    // One extra stage: the tag reaches the top bit on the edge conv_data
    // becomes valid, so the DAC register captures on the following edge.
    logic [CONV_LATENCY:0] tag_line;

    assign s_tready = !full;
    assign push     = s_tvalid && !full;
    assign tick     = run && (tick_cnt >= rate_div);
    assign pop      = tick && !empty;
    assign underrun = tick && empty;

    // Priming looks at the occupancy this edge will produce, so the push
    // that reaches PRIME_LEVEL also moves the FSM to RUN.
    assign prime_met = (fifo_level + LW'(push)) >= LW'(PRIME_LEVEL);

    assign busy = (state != IDLE) || (|tag_line) || dac_strobe;

    dac_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32),
        .LW    (LW)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (push),
        .push_data (s_tdata),
        .pop       (pop),
        .head      (head),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = PRIME;
            PRIME:   if (!enable) state_nxt = IDLE;
                     else if (prime_met) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ticks stop in the cycle enable drops, even before the FSM leaves RUN.
    always_comb begin
        run = 1'b0;
        case (state)
            RUN:     run = enable;
            default: run = 1'b0;
        endcase
    end

    // Holding the counter at rate_div outside RUN makes the first RUN cycle a tick.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                  tick_cnt <= '0;
        else if (!run)                 tick_cnt <= rate_div;
        else if (tick_cnt >= rate_div) tick_cnt <= '0;
        else                           tick_cnt <= tick_cnt + DIV_WIDTH'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            conv_float <= 32'h0;
            tag_line   <= '0;
            dac_data   <= 14'h2000;
            dac_strobe <= 1'b0;
        end else begin
            if (tick) conv_float <= empty ? 32'h0 : head;
            tag_line   <= {tag_line[CONV_LATENCY-1:0], tick};
            dac_strobe <= tag_line[CONV_LATENCY];
            if (tag_line[CONV_LATENCY]) dac_data <= conv_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                underrun_cnt <= '0;
        else if (clr_stats)                          underrun_cnt <= '0;
        else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb/tb_dac_sample_scheduler.sv - directed self-checking bench for dac_sample_scheduler

module tb_dac_sample_scheduler;
    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [15:0] rate_div;
    logic        clr_stats;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] conv_float;
    logic [13:0] conv_data;
    logic [13:0] dac_data;
    logic        dac_strobe;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_cnt;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    logic [13:0] sq[$];
    int          st[$];

    logic [13:0] p0 = 14'h2000;
    logic [13:0] p1 = 14'h2000;
    logic [13:0] p2 = 14'h2000;
    logic [13:0] p3 = 14'h2000;

    logic [31:0] fl [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

    dac_sample_scheduler dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .rate_div     (rate_div),
        .clr_stats    (clr_stats),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .conv_float   (conv_float),
        .conv_data    (conv_data),
        .dac_data     (dac_data),
        .dac_strobe   (dac_strobe),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [13:0] f2ob(input logic [31:0] f);
        int          e;
        int          mag;
        logic [23:0] m;
        e = int'(f[30:23]);
        m = {1'b1, f[22:0]};
        if (e < 127)      mag = 0;
        else if (e > 140) mag = 8192;
        else              mag = int'(m >> (150 - e));
        if (f[31]) return (mag >= 8192) ? 14'd0 : 14'(8192 - mag);
        else       return (mag >= 8191) ? 14'h3FFF : 14'(8192 + mag);
    endfunction

    // Converter model: four edges from conv_float to conv_data.
    always @(posedge aclk) begin
        p0 <= f2ob(conv_float);
        p1 <= p0;
        p2 <= p1;
        p3 <= p2;
    end
    assign conv_data = p3;

    always @(negedge aclk) begin
        if (dac_strobe === 1'b1) begin
            sq.push_back(dac_data);
            st.push_back(cyc);
        end
    end

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int t_conv;
        int nxt;
        logic acc;
        int n_acc;
        logic [31:0] t1v [4];

        t1v = '{32'h3F800000, 32'h45000000, 32'hC5000000, 32'h00000000};
        aresetn = 1'b0; enable = 1'b0; rate_div = 16'd3; clr_stats = 1'b0;
        s_tdata = 32'h0; s_tvalid = 1'b0;
        step(); step();
        chk("rst_tready", s_tready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_dac", dac_data, 14'h2000);
        chk("rst_strobe", dac_strobe, 0);
        chk("rst_conv", conv_float, 0);
        chk("rst_ucnt", underrun_cnt, 0);
        chk("rst_busy", busy, 0);
        @(negedge aclk); aresetn = 1'b1; #1;

        // Prime and latency, rate_div=3
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_tdata = t1v[i]; s_tvalid = 1'b1;
            step();
        end
        s_tvalid = 1'b0;
        chk("t1_level4", fifo_level, 4);
        chk("t1_conv_pre", conv_float, 0);
        step();
        chk("t1_conv_first", conv_float, 32'h3F800000);
        chk("t1_level3", fifo_level, 3);
        t_conv = cyc;
        repeat (18) step();
        chk("t1_nstrobe", sq.size(), 4);
        chk("t1_d0", sq[0], 14'h2001);
        chk("t1_d1", sq[1], 14'h2800);
        chk("t1_d2", sq[2], 14'h1800);
        chk("t1_d3", sq[3], 14'h2000);
        chk("t1_lat", st[0] - t_conv, 5);
        chk("t1_gap01", st[1] - st[0], 4);
        chk("t1_gap23", st[3] - st[2], 4);
        enable = 1'b0;
        repeat (8) step();
        clr_stats = 1'b1; step(); clr_stats = 1'b0;
        chk("t1_clr", underrun_cnt, 0);

        // Underrun, rate_div=0
        sq.delete(); st.delete();
        rate_div = 16'd0;
        for (int i = 0; i < 4; i++) begin
            s_tdata = fl[i]; s_tvalid = 1'b1;
            step();
        end
        s_tvalid = 1'b0;
        enable = 1'b1;
        repeat (9) step();
        chk("t2_ucnt3", underrun_cnt, 3);
        chk("t2_empty", fifo_level, 0);
        repeat (6) step();
        chk("t2_nstrobe", sq.size() >= 7, 1);
        chk("t2_d0", sq[0], 14'h2001);
        chk("t2_d1", sq[1], 14'h2002);
        chk("t2_d2", sq[2], 14'h2003);
        chk("t2_d3", sq[3], 14'h2004);
        chk("t2_d4", sq[4], 14'h2000);
        chk("t2_d6", sq[6], 14'h2000);
        chk("t2_span", st[6] - st[0], 6);
        clr_stats = 1'b1; step(); clr_stats = 1'b0;
        chk("t2_clr_wins", underrun_cnt, 0);
        step();
        chk("t2_after_clr", underrun_cnt, 1);
        enable = 1'b0;
        repeat (8) step();

        // Full and backpressure
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            s_tdata = fl[n_acc]; s_tvalid = 1'b1;
            acc = s_tready;
            step();
            if (acc) n_acc++;
        end
        chk("t3_accepted", n_acc, 8);
        chk("t3_tready0", s_tready, 0);
        chk("t3_level8", fifo_level, 8);
        sq.delete(); st.delete();
        s_tdata = fl[8];
        enable = 1'b1; rate_div = 16'd0;
        step(); step();
        chk("t3_tready_still0", s_tready, 0);
        step();
        chk("t3_tready_rise", s_tready, 1);
        chk("t3_level7", fifo_level, 7);
        nxt = 8;
        for (int k = 0; k < 20 && nxt < 12; k++) begin
            acc = s_tready;
            step();
            if (acc) nxt++;
            s_tdata = fl[nxt];
        end
        s_tvalid = 1'b0;
        chk("t3_pushed", nxt, 12);
        repeat (20) step();
        chk("t3_nstrobe", sq.size() >= 12, 1);
        for (int i = 0; i < 12; i++) chk("t3_order", sq[i], 14'h2001 + 14'(i));
        chk("t3_span", st[11] - st[0], 11);
        enable = 1'b0;
        repeat (8) step();

        // Enable drop mid-stream
        for (int i = 0; i < 8; i++) begin
            s_tdata = fl[i]; s_tvalid = 1'b1;
            step();
        end
        s_tvalid = 1'b0;
        sq.delete(); st.delete();
        enable = 1'b1;
        repeat (5) step();
        enable = 1'b0;
        repeat (5) step();
        chk("t4_busy_at_last", busy, 1);
        chk("t4_strobe_last", dac_strobe, 1);
        step();
        chk("t4_busy_fall", busy, 0);
        repeat (5) step();
        chk("t4_nstrobe", sq.size(), 3);
        chk("t4_d0", sq[0], 14'h2001);
        chk("t4_d2", sq[2], 14'h2003);
        chk("t4_retained", fifo_level, 5);
        chk("t4_conv_hold", conv_float, 32'h40400000);
        enable = 1'b1;
        step(); step();
        chk("t4_conv_pre", conv_float, 32'h40400000);
        step();
        chk("t4_no_reprime", conv_float, 32'h40800000);

        // Async reset mid-RUN
        repeat (6) step();
        chk("t5_pre_dac", dac_data, 14'h2005);
        chk("t5_pre_strobe", dac_strobe, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_dac", dac_data, 14'h2000);
        chk("t5_strobe", dac_strobe, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_tready", s_tready, 1);
        @(negedge aclk); aresetn = 1'b1; #1;
        sq.delete(); st.delete();
        repeat (15) step();
        chk("t5_no_strobe", sq.size(), 0);
        chk("t5_conv", conv_float, 0);

        // Saturation
        for (int i = 0; i < 4; i++) begin
            s_tdata = fl[i]; s_tvalid = 1'b1;
            step();
        end
        s_tvalid = 1'b0;
        repeat (65550) step();
        chk("t6_sat", underrun_cnt, 16'hFFFF);
        repeat (5) step();
        chk("t6_sat_hold", underrun_cnt, 16'hFFFF);
        enable = 1'b0;
        clr_stats = 1'b1; step(); clr_stats = 1'b0;
        chk("t6_clr", underrun_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
